// File: rtl/timer_pkg.sv
// Shared definitions for the timer prescaler and its configuration sequencer.
package timer_pkg;

  localparam int DIV_W    = 4;
  localparam int WAIT_MAX = 255;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/timer_cfg_ctrl.sv
// Configuration sequencer for the timer prescaler. Software writes take effect
// immediately when the timer is off or the divider is unchanged. A divider change
// while running is held in a shadow until a prescaler tick (or a timeout), then
// applied through a one-cycle drain with the timer disabled.
module timer_cfg_ctrl #(
  parameter int DIV_W    = timer_pkg::DIV_W,
  parameter int WAIT_MAX = timer_pkg::WAIT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic             cfg_timer_en,
  input  logic             cfg_div_en,
  input  logic [DIV_W-1:0] cfg_div_val,
  input  logic             cnt_en,
  input  logic             halt_ack,
  input  logic             dbg_mode,
  input  logic             dbg_halt_req,
  output logic             timer_en,
  output logic             div_en,
  output logic [DIV_W-1:0] div_val,
  output logic             halt_req,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             halted
);

  import timer_pkg::*;

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t             state, state_n;
  logic               timer_en_n, div_en_n;
  logic [DIV_W-1:0]   div_val_n;
  logic               shadow_en, shadow_en_n;
  logic [DIV_W-1:0]   shadow_val, shadow_val_n;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_n;
  logic               done_n, err_n;
  logic               disable_wr;
  logic               pend_exit;

  assign disable_wr = cfg_wr & ~cfg_timer_en;
  assign pend_exit  = cnt_en | ((wait_cnt == WAIT_W'(WAIT_MAX)) & ~halt_ack);
  assign cfg_busy   = (state == PEND) || (state == DRAIN);

  // Next-state and next-output decode; a disable write always wins over a pending change.
  always_comb begin
    state_n      = state;
    timer_en_n   = timer_en;
    div_en_n     = div_en;
    div_val_n    = div_val;
    shadow_en_n  = shadow_en;
    shadow_val_n = shadow_val;
    wait_cnt_n   = wait_cnt;
    done_n       = 1'b0;
    err_n        = 1'b0;
    case (state)
      OFF: begin
        if (cfg_wr) begin
          timer_en_n = cfg_timer_en;
          div_en_n   = cfg_div_en;
          div_val_n  = cfg_div_val;
          done_n     = 1'b1;
          state_n    = cfg_timer_en ? RUN : OFF;
        end
      end
      RUN: begin
        if (disable_wr) begin
          timer_en_n = 1'b0;
          div_en_n   = cfg_div_en;
          div_val_n  = cfg_div_val;
          done_n     = 1'b1;
          state_n    = OFF;
        end else if (cfg_wr) begin
          if ((cfg_div_en == div_en) && (cfg_div_val == div_val)) begin
            done_n = 1'b1;
          end else begin
            shadow_en_n  = cfg_div_en;
            shadow_val_n = cfg_div_val;
            wait_cnt_n   = '0;
            state_n      = PEND;
          end
        end
      end
      PEND: begin
        if (disable_wr) begin
          timer_en_n = 1'b0;
          div_en_n   = cfg_div_en;
          div_val_n  = cfg_div_val;
          done_n     = 1'b1;
          state_n    = OFF;
        end else begin
          err_n = cfg_wr;
          if (pend_exit) begin
            timer_en_n = 1'b0;
            div_en_n   = shadow_en;
            div_val_n  = shadow_val;
            state_n    = DRAIN;
          end else if (!halt_ack) begin
            wait_cnt_n = wait_cnt + WAIT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (disable_wr) begin
          timer_en_n = 1'b0;
          div_en_n   = cfg_div_en;
          div_val_n  = cfg_div_val;
          done_n     = 1'b1;
          state_n    = OFF;
        end else begin
          err_n      = cfg_wr;
          timer_en_n = 1'b1;
          done_n     = 1'b1;
          state_n    = RUN;
        end
      end
      default: state_n = OFF;
    endcase
  end

  // State, output, shadow and timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      timer_en   <= 1'b0;
      div_en     <= 1'b0;
      div_val    <= '0;
      shadow_en  <= 1'b0;
      shadow_val <= '0;
      wait_cnt   <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      timer_en   <= timer_en_n;
      div_en     <= div_en_n;
      div_val    <= div_val_n;
      shadow_en  <= shadow_en_n;
      shadow_val <= shadow_val_n;
      wait_cnt   <= wait_cnt_n;
      cfg_done   <= done_n;
      cfg_err    <= err_n;
    end
  end

  // Debug halt handshake, registered in both directions regardless of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_req <= 1'b0;
      halted   <= 1'b0;
    end else begin
      halt_req <= dbg_mode & dbg_halt_req;
      halted   <= halt_ack;
    end
  end

endmodule

// File: tb/tb_timer_cfg_ctrl.sv
// Scenario bench for timer_cfg_ctrl: each test builds a table of per-cycle
// stimulus with the expected outputs for the following cycle.
module tb_timer_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_wr = 1'b0, cfg_timer_en = 1'b0, cfg_div_en = 1'b0;
  logic [3:0] cfg_div_val = '0;
  logic       cnt_en = 1'b0, halt_ack = 1'b0, dbg_mode = 1'b0, dbg_halt_req = 1'b0;
  logic       timer_en, div_en, halt_req, cfg_busy, cfg_done, cfg_err, halted;
  logic [3:0] div_val;

  typedef struct packed {
    logic       ten;
    logic       den;
    logic [3:0] dval;
    logic       done;
    logic       err;
    logic       busy;
    logic       hreq;
    logic       halted;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       wr;
    logic       ten;
    logic       den;
    logic [3:0] dval;
    logic       cnt;
    logic       hack;
    logic       dm;
    logic       dr;
    obs_t       exp;
  } step_t;

  step_t plan[$];
  obs_t  sb[$];
  int    compared = 0;
  int    mismatched = 0;

  timer_cfg_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_timer_en(cfg_timer_en),
    .cfg_div_en(cfg_div_en), .cfg_div_val(cfg_div_val), .cnt_en(cnt_en),
    .halt_ack(halt_ack), .dbg_mode(dbg_mode), .dbg_halt_req(dbg_halt_req),
    .timer_en(timer_en), .div_en(div_en), .div_val(div_val), .halt_req(halt_req),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .halted(halted)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic obs_t mk(logic ten, logic den, logic [3:0] dval, logic done,
                              logic err, logic busy, logic hreq, logic hlt);
    obs_t o;
    o.ten = ten; o.den = den; o.dval = dval; o.done = done;
    o.err = err; o.busy = busy; o.hreq = hreq; o.halted = hlt;
    return o;
  endfunction

  function automatic void add(logic r, logic wr, logic ten, logic den, logic [3:0] dval,
                              logic cnt, logic hack, logic dm, logic dr, obs_t e);
    step_t s;
    s.rst = r; s.wr = wr; s.ten = ten; s.den = den; s.dval = dval;
    s.cnt = cnt; s.hack = hack; s.dm = dm; s.dr = dr; s.exp = e;
    plan.push_back(s);
  endfunction

  function automatic obs_t observe();
    return mk(timer_en, div_en, div_val, cfg_done, cfg_err, cfg_busy, halt_req, halted);
  endfunction

  task automatic drive(input step_t s);
    rst = s.rst; cfg_wr = s.wr; cfg_timer_en = s.ten; cfg_div_en = s.den;
    cfg_div_val = s.dval; cnt_en = s.cnt; halt_ack = s.hack;
    dbg_mode = s.dm; dbg_halt_req = s.dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    add(1, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(0, 0, 4'd0, 0, 0, 0, 0, 0));
    add(1, 1, 1, 1, 4'd9, 1, 1, 1, 1, mk(0, 0, 4'd0, 0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); sb.push_back(plan[i].exp); tick();
      want = sb.pop_front(); got = observe(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL reset step %0d: got %b required %b", i, got, want);
      end
    end
    plan.delete();
  endtask

  task automatic test_enable();
    obs_t got, want;
    add(0, 1, 1, 1, 4'd3, 0, 0, 0, 0, mk(1, 1, 4'd3, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd3, 0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); sb.push_back(plan[i].exp); tick();
      want = sb.pop_front(); got = observe(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL enable step %0d: got %b required %b", i, got, want);
      end
    end
    plan.delete();
  endtask

  task automatic test_div_change();
    obs_t got, want;
    add(0, 1, 1, 1, 4'd5, 0, 0, 0, 0, mk(1, 1, 4'd3, 0, 0, 1, 0, 0));
    for (int k = 0; k < 9; k++)
      add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd3, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 4'd0, 1, 0, 0, 0, mk(0, 1, 4'd5, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd5, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd5, 0, 0, 0, 0, 0));
    add(0, 1, 1, 1, 4'd5, 0, 0, 0, 0, mk(1, 1, 4'd5, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 4'd0, 1, 0, 0, 0, mk(1, 1, 4'd5, 0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); sb.push_back(plan[i].exp); tick();
      want = sb.pop_front(); got = observe(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL div_change step %0d: got %b required %b", i, got, want);
      end
    end
    plan.delete();
  endtask

  task automatic test_forced_apply();
    obs_t got, want;
    add(0, 1, 1, 0, 4'd2, 0, 0, 0, 0, mk(1, 1, 4'd5, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 255; k++)
      add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd5, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(0, 0, 4'd2, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 0, 4'd2, 1, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); sb.push_back(plan[i].exp); tick();
      want = sb.pop_front(); got = observe(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL forced_apply step %0d: got %b required %b", i, got, want);
      end
    end
    plan.delete();
  endtask

  task automatic test_halt_freeze();
    obs_t got, want;
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 1, mk(1, 0, 4'd2, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 1, 1, mk(1, 0, 4'd2, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 1, 0, mk(1, 0, 4'd2, 0, 0, 0, 0, 0));
    add(0, 1, 1, 1, 4'd7, 0, 0, 0, 0, mk(1, 0, 4'd2, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 100; k++)
      add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 0, 4'd2, 0, 0, 1, 0, 0));
    for (int k = 0; k < 1000; k++)
      add(0, 0, 0, 0, 4'd0, 0, 1, 1, 1, mk(1, 0, 4'd2, 0, 0, 1, 1, 1));
    for (int k = 101; k <= 255; k++)
      add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 0, 4'd2, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(0, 1, 4'd7, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd7, 1, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); sb.push_back(plan[i].exp); tick();
      want = sb.pop_front(); got = observe(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL halt_freeze step %0d: got %b required %b", i, got, want);
      end
    end
    plan.delete();
  endtask

  task automatic test_write_pend();
    obs_t got, want;
    add(0, 1, 1, 1, 4'd9, 0, 0, 0, 0, mk(1, 1, 4'd7, 0, 0, 1, 0, 0));
    add(0, 1, 1, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd7, 0, 1, 1, 0, 0));
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd7, 0, 0, 1, 0, 0));
    add(0, 1, 0, 0, 4'd0, 1, 0, 0, 0, mk(0, 0, 4'd0, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(0, 0, 4'd0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 4'd0, 1, 0, 0, 0, mk(0, 0, 4'd0, 0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); sb.push_back(plan[i].exp); tick();
      want = sb.pop_front(); got = observe(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL write_pend step %0d: got %b required %b", i, got, want);
      end
    end
    plan.delete();
  endtask

  task automatic test_off_config();
    obs_t got, want;
    add(0, 1, 0, 1, 4'd6, 0, 0, 0, 0, mk(0, 1, 4'd6, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 4'd0, 1, 0, 0, 0, mk(0, 1, 4'd6, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 4'd1, 0, 0, 0, 0, mk(0, 0, 4'd1, 1, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); sb.push_back(plan[i].exp); tick();
      want = sb.pop_front(); got = observe(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL off_config step %0d: got %b required %b", i, got, want);
      end
    end
    plan.delete();
  endtask

  task automatic test_reset_drain();
    obs_t got, want;
    add(0, 1, 1, 1, 4'd3, 0, 0, 0, 0, mk(1, 1, 4'd3, 1, 0, 0, 0, 0));
    add(0, 1, 1, 1, 4'd4, 0, 0, 0, 0, mk(1, 1, 4'd3, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 4'd0, 1, 0, 0, 0, mk(0, 1, 4'd4, 0, 0, 1, 0, 0));
    add(1, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(0, 0, 4'd0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(0, 0, 4'd0, 0, 0, 0, 0, 0));
    add(0, 1, 1, 1, 4'd1, 0, 0, 0, 0, mk(1, 1, 4'd1, 1, 0, 0, 0, 0));
    add(0, 1, 1, 1, 4'd2, 1, 0, 0, 0, mk(1, 1, 4'd1, 0, 0, 1, 0, 0));
    add(0, 1, 1, 1, 4'd8, 1, 0, 0, 0, mk(0, 1, 4'd2, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, mk(1, 1, 4'd2, 1, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); sb.push_back(plan[i].exp); tick();
      want = sb.pop_front(); got = observe(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL reset_drain step %0d: got %b required %b", i, got, want);
      end
    end
    plan.delete();
  endtask

  // Scenario sequence; each test starts from the state the previous one left.
  initial begin
    test_reset();
    test_enable();
    test_div_change();
    test_forced_apply();
    test_halt_freeze();
    test_write_pend();
    test_off_config();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
